// File: rtl/gf2m_serial_mult.sv
// Bit-serial GF(2^m) multiplier, polynomial basis, MSB-first shift-and-add.
// One product every M+1 cycles; the result and its valid level are held
// until the next request is accepted.
module gf2m_serial_mult #(
  parameter int          M    = 163,
  parameter logic [M-1:0] POLY = 163'hC9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic         o_out_valid,
  output logic [M-1:0] o_c,
  output logic         o_busy
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [M-1:0]  r_acc;
  logic [M-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_c;
  logic          r_out_valid;
  logic          r_busy;

  logic [M-1:0]  w_acc_next;
  logic [M-1:0]  w_a_next;
  logic [M-1:0]  w_b_next;
  logic [CW-1:0] w_cnt_next;
  logic [M-1:0]  w_c_next;
  logic          w_out_valid_next;
  logic          w_busy_next;

  logic [M-1:0]  w_acc_step;
  logic          w_start;
  logic          w_last;

  // One MSB-first step: multiply acc by x, fold the overflowing x^M term
  // back in as POLY, then add a if the current multiplier bit is set.
  assign w_acc_step = {r_acc[M-2:0], 1'b0}
                    ^ (r_acc[M-1] ? POLY : '0)
                    ^ (r_b[M-1]   ? r_a  : '0);

  // A request is only honoured outside RUN; requests during RUN are dropped.
  assign w_start = i_in_valid && (r_state != S_RUN);
  assign w_last  = (r_state == S_RUN) && (r_cnt == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE:  if (i_in_valid) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and output next values; all outputs are then registered.
  always_comb begin
    w_acc_next       = r_acc;
    w_a_next         = r_a;
    w_b_next         = r_b;
    w_cnt_next       = r_cnt;
    w_c_next         = r_c;
    w_out_valid_next = r_out_valid;
    w_busy_next      = r_busy;
    if (w_start) begin
      w_a_next         = i_a;
      w_b_next         = i_b;
      w_acc_next       = '0;
      w_cnt_next       = CNT_LAST;
      w_busy_next      = 1'b1;
      w_out_valid_next = 1'b0;
    end else if (r_state == S_RUN) begin
      w_acc_next = w_acc_step;
      w_b_next   = {r_b[M-2:0], 1'b0};
      if (w_last) begin
        w_c_next         = w_acc_step;
        w_out_valid_next = 1'b1;
        w_busy_next      = 1'b0;
      end else begin
        w_cnt_next = r_cnt - 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_acc       <= w_acc_next;
      r_a         <= w_a_next;
      r_b         <= w_b_next;
      r_cnt       <= w_cnt_next;
      r_c         <= w_c_next;
      r_out_valid <= w_out_valid_next;
      r_busy      <= w_busy_next;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_c         = r_c;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_gf2m_serial_mult.sv
// Self-checking bench for gf2m_serial_mult: an M=163 instance and an M=4
// instance, checked cycle by cycle against a long-division GF(2^m) model.
module tb_gf2m_serial_mult;

  localparam int MB = 163;
  localparam int MS = 4;
  localparam logic [MB-1:0] POLY_B = 163'hC9;
  localparam logic [MS-1:0] POLY_S = 4'h3;

  logic clk;
  logic rst_n;

  logic          b_in_valid;
  logic [MB-1:0] b_a, b_b, b_c;
  logic          b_out_valid, b_busy;

  logic          s_in_valid;
  logic [MS-1:0] s_a, s_b, s_c;
  logic          s_out_valid, s_busy;

  int vectors;
  int miscompares;
  logic [MB-1:0] last_c;

  gf2m_serial_mult #(.M(MB), .POLY(POLY_B)) u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(b_in_valid),
    .i_a(b_a), .i_b(b_b),
    .o_out_valid(b_out_valid), .o_c(b_c), .o_busy(b_busy)
  );

  gf2m_serial_mult #(.M(MS), .POLY(POLY_S)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(s_in_valid),
    .i_a(s_a), .i_b(s_b),
    .o_out_valid(s_out_valid), .o_c(s_c), .o_busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full carry-less product, then polynomial long division by f.
  function automatic logic [MB-1:0] ref_mul(input logic [MB-1:0] a,
                                            input logic [MB-1:0] b,
                                            input int m,
                                            input logic [MB-1:0] poly);
    logic [339:0] p;
    logic [339:0] f;
    p = '0;
    for (int i = 0; i < m; i++)
      if (b[i]) p = p ^ ({177'b0, a} << i);
    f = {177'b0, poly};
    f[m] = 1'b1;
    for (int i = 2 * m - 2; i >= m; i--)
      if (p[i]) p = p ^ (f << (i - m));
    return p[MB-1:0];
  endfunction

  function automatic logic [MB-1:0] rand_big();
    logic [MB-1:0] v;
    for (int i = 0; i < MB; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  // Issue one request on the big instance and check every cycle up to the result.
  // With poke set, a second request with other operands is pulsed mid-run.
  task automatic run_big(input logic [MB-1:0] a, input logic [MB-1:0] b,
                         input logic [MB-1:0] exp, input bit poke, input string nm);
    @(negedge clk);
    b_in_valid = 1'b1; b_a = a; b_b = b;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    vectors++;
    if (b_out_valid !== 1'b0 || b_busy !== 1'b1 || b_c !== last_c) begin
      miscompares++;
      $display("FAIL %s accept: ov=%b busy=%b c=%h required ov=0 busy=1 c=%h",
               nm, b_out_valid, b_busy, b_c, last_c);
    end
    for (int j = 1; j <= MB; j++) begin
      if (poke && j == 10) begin
        b_in_valid = 1'b1; b_a = rand_big(); b_b = rand_big();
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      vectors++;
      if (j < MB) begin
        if (b_out_valid !== 1'b0 || b_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s cycle %0d: ov=%b busy=%b required ov=0 busy=1",
                   nm, j, b_out_valid, b_busy);
        end
      end else begin
        if (b_out_valid !== 1'b1 || b_busy !== 1'b0 || b_c !== exp) begin
          miscompares++;
          $display("FAIL %s result: ov=%b busy=%b c=%h required ov=1 busy=0 c=%h",
                   nm, b_out_valid, b_busy, b_c, exp);
        end
      end
    end
    $display("big %s: a=%h b=%h c=%h", nm, a, b, b_c);
    last_c = exp;
  endtask

  task automatic run_small(input logic [MS-1:0] a, input logic [MS-1:0] b,
                           input logic [MS-1:0] exp, input string nm);
    @(negedge clk);
    s_in_valid = 1'b1; s_a = a; s_b = b;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    for (int j = 1; j <= MS; j++) begin
      @(posedge clk); #1;
      vectors++;
      if (j < MS) begin
        if (s_out_valid !== 1'b0 || s_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s cycle %0d: ov=%b busy=%b required ov=0 busy=1",
                   nm, j, s_out_valid, s_busy);
        end
      end else if (s_out_valid !== 1'b1 || s_busy !== 1'b0 || s_c !== exp) begin
        miscompares++;
        $display("FAIL %s result: ov=%b busy=%b c=%h required ov=1 busy=0 c=%h",
                 nm, s_out_valid, s_busy, s_c, exp);
      end
    end
    $display("small %s: a=%h b=%h c=%h", nm, a, b, s_c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = i[0]; s_in_valid = i[0];
      b_a = rand_big(); b_b = rand_big(); s_a = 4'hF; s_b = 4'hF;
      @(posedge clk); #1;
      vectors++;
      if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_c !== '0 ||
          s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_c !== '0) begin
        miscompares++;
        $display("FAIL reset_hold: big ov=%b busy=%b c=%h small ov=%b busy=%b c=%h required all 0",
                 b_out_valid, b_busy, b_c, s_out_valid, s_busy, s_c);
      end
    end
    @(negedge clk);
    b_in_valid = 1'b0; s_in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: ov=%b busy=%b sbusy=%b required 0 0 0",
               b_out_valid, b_busy, s_busy);
    end
    $display("reset: done");
    last_c = '0;
  endtask

  task automatic test_identity();
    logic [MB-1:0] bv;
    bv = 163'h5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    run_big(163'd1, bv, bv, 1'b0, "identity");
  endtask

  task automatic test_async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_c !== '0) begin
      miscompares++;
      $display("FAIL async_reset: ov=%b busy=%b c=%h required 0 0 0",
               b_out_valid, b_busy, b_c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_c = '0;
    $display("async reset: cleared between edges");
  endtask

  task automatic test_reduction_wrap();
    logic [MB-1:0] top;
    top = '0;
    top[MB-1] = 1'b1;
    run_big(top, 163'd2, 163'hC9, 1'b0, "wrap_x163");
    run_big(top, top, ref_mul(top, top, MB, POLY_B), 1'b0, "wrap_x324");
  endtask

  task automatic test_random();
    logic [MB-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = rand_big(); b = rand_big();
      a[MB-1] = $urandom_range(0, 1);
      run_big(a, b, ref_mul(a, b, MB, POLY_B), 1'b0, "random");
    end
    run_big('0, rand_big(), '0, 1'b0, "zero_a");
  endtask

  task automatic test_small_field();
    logic [MS-1:0] a, b;
    logic [MB-1:0] e;
    run_small(4'h8, 4'h2, 4'h3, "x3_times_x");
    run_small(4'h6, 4'h3, 4'hA, "six_times_three");
    run_small(4'h0, 4'hF, 4'h0, "zero_a");
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom); b = 4'($urandom);
      e = ref_mul({159'b0, a}, {159'b0, b}, MS, {159'b0, POLY_S});
      run_small(a, b, e[MS-1:0], "random");
    end
  endtask

  task automatic test_protocol();
    logic [MB-1:0] a, b, held;
    a = rand_big(); b = rand_big();
    run_big(a, b, ref_mul(a, b, MB, POLY_B), 1'b1, "ignore_in_run");
    held = b_c;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (b_out_valid !== 1'b1 || b_busy !== 1'b0 || b_c !== last_c) begin
        miscompares++;
        $display("FAIL done_hold cycle %0d: ov=%b busy=%b c=%h required ov=1 busy=0 c=%h",
                 i, b_out_valid, b_busy, b_c, last_c);
      end
    end
    $display("done hold: 20 cycles c=%h", held);
    // back-to-back from DONE; run_big checks OV falls after the accepting edge
    a = rand_big(); b = rand_big();
    run_big(a, b, ref_mul(a, b, MB, POLY_B), 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    b_in_valid = 1'b1; b_a = rand_big(); b_b = rand_big();
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    // after edge k+82 the countdown sits at 80
    for (int j = 0; j < 82; j++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_c !== '0) begin
      miscompares++;
      $display("FAIL mid_run_reset: ov=%b busy=%b c=%h required 0 0 0",
               b_out_valid, b_busy, b_c);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(posedge clk); #1;
      vectors++;
      if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_after_reset cycle %0d: ov=%b busy=%b required 0 0",
                 j, b_out_valid, b_busy);
      end
    end
    last_c = '0;
    run_big(163'd3, 163'd3, 163'd5, 1'b0, "restart_3x3");
  endtask

  initial begin
    vectors = 0; miscompares = 0; last_c = '0;
    rst_n = 1'b0;
    b_in_valid = 1'b0; b_a = '0; b_b = '0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0;
    test_reset();
    test_identity();
    test_async_reset();
    test_reduction_wrap();
    test_random();
    test_small_field();
    test_protocol();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
